// File: rtl/dmi_jtag_tap.sv
// dmi_jtag_tap: 1149.1 TAP + DTM IR/IDCODE/BYPASS/DTMCS front end; RV_DTM_HARDRESET_EN adds dmi_hard_reset_o
module dmi_jtag_tap #(
    parameter logic [31:0] IdcodeValue = 32'h00000001,
    parameter logic [2:0]  IdleCycles  = 3'd1,
    parameter logic [5:0]  AddrBits    = 6'd7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tms_i,
    input  logic       tdi_i,
    output logic       tdo_o,
    output logic       tdo_oe_o,
    output logic       test_logic_reset_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       dmi_access_o,
    output logic       dtmcs_select_o,
    output logic       dmi_reset_o,
`ifdef RV_DTM_HARDRESET_EN
    output logic       dmi_hard_reset_o,
`endif
    output logic       dmi_tdi_o,
    input  logic       dmi_tdo_i,
    input  logic [1:0] dmi_error_i
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } state_e;

    state_e      r_state, w_next;
    logic [4:0]  r_ir, r_ir_sr;
    logic [31:0] r_idcode_sr, r_dtmcs_sr;
    logic        r_bypass, r_tdo;
    logic        w_sel_idcode, w_sel_bypass, w_dr_tdo, w_dtmcs_upd;

    always_ff @(posedge clk_i) r_state <= rst_i ? TLR : w_next;

    always_comb begin
        w_next = TLR;
        case (r_state)
            TLR:     w_next = tms_i ? TLR    : RTI;
            RTI:     w_next = tms_i ? SEL_DR : RTI;
            SEL_DR:  w_next = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  w_next = tms_i ? EX1_DR : SH_DR;
            SH_DR:   w_next = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  w_next = tms_i ? UPD_DR : PA_DR;
            PA_DR:   w_next = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  w_next = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  w_next = tms_i ? SEL_DR : RTI;
            SEL_IR:  w_next = tms_i ? TLR    : CAP_IR;
            CAP_IR:  w_next = tms_i ? EX1_IR : SH_IR;
            SH_IR:   w_next = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  w_next = tms_i ? UPD_IR : PA_IR;
            PA_IR:   w_next = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  w_next = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  w_next = tms_i ? SEL_DR : RTI;
            default: w_next = TLR;
        endcase
    end

    assign test_logic_reset_o = r_state == TLR;
    assign capture_dr_o       = r_state == CAP_DR;
    assign shift_dr_o         = r_state == SH_DR;
    assign update_dr_o        = r_state == UPD_DR;
    assign tdo_oe_o           = shift_dr_o || r_state == SH_IR;
    assign dmi_access_o       = r_ir == 5'h11;
    assign dtmcs_select_o     = r_ir == 5'h10;
    assign w_sel_idcode       = r_ir == 5'h01;
    assign w_sel_bypass       = !(dmi_access_o || dtmcs_select_o || w_sel_idcode);
    assign dmi_tdi_o          = tdi_i;
    assign tdo_o              = r_tdo;
    assign w_dtmcs_upd        = update_dr_o && dtmcs_select_o;
`ifdef RV_DTM_HARDRESET_EN
    assign dmi_hard_reset_o   = w_dtmcs_upd && r_dtmcs_sr[17];
    assign dmi_reset_o        = w_dtmcs_upd && (r_dtmcs_sr[16] || r_dtmcs_sr[17]);
`else
    assign dmi_reset_o        = w_dtmcs_upd && r_dtmcs_sr[16];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ir        <= 5'h01;
            r_ir_sr     <= '0;
            r_idcode_sr <= '0;
            r_dtmcs_sr  <= '0;
            r_bypass    <= 1'b0;
        end else begin
            if (r_state == TLR) r_ir <= 5'h01;
            else if (r_state == UPD_IR) r_ir <= r_ir_sr;
            if (r_state == CAP_IR) r_ir_sr <= 5'b00001;
            else if (r_state == SH_IR) r_ir_sr <= {tdi_i, r_ir_sr[4:1]};
            if (capture_dr_o && w_sel_idcode) r_idcode_sr <= IdcodeValue | 32'h1;
            else if (shift_dr_o && w_sel_idcode) r_idcode_sr <= {tdi_i, r_idcode_sr[31:1]};
            if (capture_dr_o && dtmcs_select_o)
                r_dtmcs_sr <= {14'b0, 1'b0, 1'b0, 1'b0, IdleCycles, dmi_error_i, AddrBits, 4'h1};
            else if (shift_dr_o && dtmcs_select_o) r_dtmcs_sr <= {tdi_i, r_dtmcs_sr[31:1]};
            if (capture_dr_o && w_sel_bypass) r_bypass <= 1'b0;
            else if (shift_dr_o && w_sel_bypass) r_bypass <= tdi_i;
        end
    end

    assign w_dr_tdo = dmi_access_o ? dmi_tdo_i : dtmcs_select_o ? r_dtmcs_sr[0] :
                      w_sel_idcode ? r_idcode_sr[0] : r_bypass;

    // TDO launches on the falling edge so the debugger can sample it on the next rising edge
    always_ff @(negedge clk_i) begin
        if (rst_i) r_tdo <= 1'b0;
        else if (r_state == SH_IR) r_tdo <= r_ir_sr[0];
        else if (shift_dr_o) r_tdo <= w_dr_tdo;
    end
endmodule

// File: tb/tb_dmi_jtag_tap.sv
// tb_dmi_jtag_tap: directed TAP/DTMCS scans with hand-computed expectations
module tb_dmi_jtag_tap;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tms_i = 1'b1;
    logic       tdi_i = 1'b0;
    logic       tdo_o, tdo_oe_o, test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o;
    logic       dmi_access_o, dtmcs_select_o, dmi_reset_o, dmi_tdi_o;
    logic       dmi_tdo_i = 1'b0;
    logic [1:0] dmi_error_i = 2'b00;

    int n_chk = 0, n_pass = 0;
    int cnt_cap, cnt_sh, cnt_upd, cnt_oe, cnt_oe_bad, cnt_rst, cnt_rst_sel, cnt_tdi_bad;
    logic [63:0] r_out;
    logic [4:0]  r_ir_out;

    dmi_jtag_tap dut (
        .clk_i(clk_i), .rst_i(rst_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .test_logic_reset_o(test_logic_reset_o),
        .capture_dr_o(capture_dr_o), .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o),
        .dmi_access_o(dmi_access_o), .dtmcs_select_o(dtmcs_select_o), .dmi_reset_o(dmi_reset_o),
        .dmi_tdi_o(dmi_tdi_o), .dmi_tdo_i(dmi_tdo_i), .dmi_error_i(dmi_error_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        cnt_cap     += int'(capture_dr_o);
        cnt_sh      += int'(shift_dr_o);
        cnt_upd     += int'(update_dr_o);
        cnt_oe      += int'(tdo_oe_o);
        cnt_oe_bad  += int'(tdo_oe_o && !shift_dr_o);
        cnt_rst     += int'(dmi_reset_o);
        cnt_rst_sel += int'(dmi_reset_o && dtmcs_select_o);
        cnt_tdi_bad += int'(dmi_tdi_o !== tdi_i);
    endtask

    task automatic scan_ir(input logic [4:0] ir, output logic [4:0] out);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            out[i] = tdo_o;
            step(i == 4, ir[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, input logic [63:0] pat,
                           output logic [63:0] out);
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0; cnt_oe = 0; cnt_oe_bad = 0;
        cnt_rst = 0; cnt_rst_sel = 0;
        out = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        dmi_tdo_i = pat[0];
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            out[i] = tdo_o;
            dmi_tdo_i = pat[i+1];
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        cnt_tdi_bad = 0;
        step(1'b1, 1'b0);
        check("reset_outs", {test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o,
                             dmi_reset_o, tdo_oe_o, tdo_o}, 7'b1000000);
        check("reset_ir_sel", {dmi_access_o, dtmcs_select_o}, 2'b00);
        rst_i = 1'b0;
        step(1'b0, 1'b0);
        check("rti_not_tlr", test_logic_reset_o, 1'b0);

        scan_dr(32, 64'h0, 64'h0, r_out);
        check("idcode", r_out, 64'h1);
        check("idcode_shift_cnt", cnt_sh, 32);
        check("idcode_oe_cnt", cnt_oe, 32);
        check("oe_outside_shift", cnt_oe_bad, 0);

        scan_ir(5'h10, r_ir_out);
        check("ir_capture", r_ir_out, 5'b00001);
        check("dtmcs_sel", {dtmcs_select_o, dmi_access_o}, 2'b10);
        dmi_error_i = 2'b11;
        scan_dr(32, 64'h0, 64'h0, r_out);
        check("dtmcs_err3", r_out, 64'h1C71);
        check("dtmcs_no_pulse", cnt_rst, 0);
        dmi_error_i = 2'b00;
        scan_dr(32, 64'h0, 64'h0, r_out);
        check("dtmcs_err0", r_out, 64'h1071);
        scan_dr(32, 64'h10000, 64'h0, r_out);
        check("dmireset_pulse", cnt_rst, 1);
        check("dmireset_sel", cnt_rst_sel, 1);
        scan_dr(32, 64'h20000, 64'h0, r_out);
        check("bit17_ignored", cnt_rst, 0);

        scan_ir(5'h11, r_ir_out);
        check("dmi_sel", {dmi_access_o, dtmcs_select_o}, 2'b10);
        scan_dr(41, 64'h0, 64'h0000_015A_C3E9_6B27, r_out);
        check("dmi_tdo_mirror", r_out, 64'h0000_015A_C3E9_6B27);
        check("dmi_cap_cnt", cnt_cap, 1);
        check("dmi_sh_cnt", cnt_sh, 41);
        check("dmi_upd_cnt", cnt_upd, 1);
        check("dmi_no_pulse", cnt_rst, 0);

        scan_ir(5'h07, r_ir_out);
        check("unk_ir_sel", {dmi_access_o, dtmcs_select_o}, 2'b00);
        scan_dr(9, 64'h0A5, 64'h0, r_out);
        check("bypass", r_out, 64'h14A);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tms5_tlr", test_logic_reset_o, 1'b1);
        step(1'b0, 1'b0);
        scan_dr(32, 64'h0, 64'h0, r_out);
        check("tlr_idcode", r_out, 64'h1);

        scan_ir(5'h10, r_ir_out);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("mid_shift_tdo", {shift_dr_o, tdo_o}, 2'b11);
        rst_i = 1'b1;
        step(1'b0, 1'b1);
        check("midreset_outs", {test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o,
                                dmi_reset_o, tdo_oe_o, tdo_o}, 7'b1000000);
        rst_i = 1'b0;
        step(1'b0, 1'b0);
        scan_dr(32, 64'h0, 64'h0, r_out);
        check("post_reset_idcode", r_out, 64'h1);
        check("tdi_passthru", cnt_tdi_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
